// File: rtl/simd_wave_sequencer.sv
// Per-SIMD-unit pass sequencer: walks one issued instruction across the lane passes
// of a wave, driving register-file controls, memory request pulses and the lane mask.

module simd_lane_active #(
    parameter int LANE = 0
) (
    input  logic [31:0] base,
    input  logic [31:0] block_dim,
    input  logic        en,
    output logic        active
);
    logic [31:0] tid;

    assign tid    = base + 32'(LANE);
    assign active = en && (tid < block_dim);
endmodule

module simd_wave_sequencer #(
    parameter int WAVE_SIZE  = 32,
    parameter int LANE_WIDTH = 16,
    parameter int NUM_PASSES = (WAVE_SIZE + LANE_WIDTH - 1) / LANE_WIDTH,
    parameter int CYCLE_W    = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  logic                  inst_reg_write,
    input  logic                  inst_mem_op,
    input  logic [31:0]           wave_id,
    input  logic [31:0]           block_dim,
    output logic                  mem_req,
    input  logic                  mem_resp_valid,
    output logic [2:0]            simd_state,
    output logic [CYCLE_W-1:0]    curr_wave_cycle,
    output logic                  rf_enable,
    output logic                  reg_write,
    output logic [LANE_WIDTH-1:0] lane_active,
    output logic                  done
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQUEST = 3'd1,
        S_EXECUTE = 3'd2,
        S_WAIT    = 3'd3,
        S_UPDATE  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               state, state_n;
    logic [CYCLE_W-1:0]   pass, pass_n;
    logic                 lat_rw, lat_mem, first_wait, load;
    logic [31:0]          lat_wave, lat_dim, next_idx, cur_base;
    logic                 lanes_en;

    // First thread index of a pass; wraps in 32-bit like the thread-id math downstream.
    function automatic logic [31:0] pass_base(input logic [31:0] w, input logic [31:0] p);
        return w * 32'(WAVE_SIZE) + p * 32'(LANE_WIDTH);
    endfunction

    assign next_idx = 32'(pass) + 32'd1;

    always_comb begin
        state_n = state;
        pass_n  = pass;
        load    = 1'b0;
        case (state)
            S_IDLE: if (issue_valid) begin
                load   = 1'b1;
                pass_n = '0;
                state_n = (pass_base(wave_id, 32'd0) < block_dim) ? S_REQUEST : S_DONE;
            end
            S_REQUEST: state_n = S_EXECUTE;
            S_EXECUTE: state_n = lat_mem ? S_WAIT : S_UPDATE;
            S_WAIT:    if (mem_resp_valid) state_n = S_UPDATE;
            S_UPDATE: begin
                if (next_idx < 32'(NUM_PASSES) && pass_base(lat_wave, next_idx) < lat_dim) begin
                    state_n = S_REQUEST;
                    pass_n  = pass + CYCLE_W'(1);
                end else begin
                    state_n = S_DONE;
                    pass_n  = '0;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: begin
                state_n = S_IDLE;
                pass_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pass       <= '0;
            lat_rw     <= 1'b0;
            lat_mem    <= 1'b0;
            lat_wave   <= '0;
            lat_dim    <= '0;
            first_wait <= 1'b0;
        end else begin
            state      <= state_n;
            pass       <= pass_n;
            first_wait <= (state == S_EXECUTE);
            if (load) begin
                lat_rw   <= inst_reg_write;
                lat_mem  <= inst_mem_op;
                lat_wave <= wave_id;
                lat_dim  <= block_dim;
            end
        end
    end

    assign issue_ready     = (state == S_IDLE);
    assign simd_state      = state;
    assign curr_wave_cycle = pass;
    assign rf_enable       = (state == S_REQUEST) || (state == S_UPDATE);
    assign reg_write       = lat_rw && (state == S_UPDATE);
    // Only the WAIT cycle entered straight from EXECUTE issues the request.
    assign mem_req         = (state == S_WAIT) && first_wait;
    assign done            = (state == S_DONE);

    assign lanes_en = (state == S_REQUEST) || (state == S_EXECUTE) ||
                      (state == S_WAIT)    || (state == S_UPDATE);
    assign cur_base = pass_base(lat_wave, 32'(pass));

    for (genvar i = 0; i < LANE_WIDTH; i++) begin : g_lane
        simd_lane_active #(.LANE(i)) u_lane (
            .base      (cur_base),
            .block_dim (lat_dim),
            .en        (lanes_en),
            .active    (lane_active[i])
        );
    end
endmodule

// File: tb/tb_simd_wave_sequencer.sv
// Self-checking bench: per-instruction expected cycle traces built from the pass rules.

module tb_simd_wave_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic        inst_reg_write = 1'b0;
    logic        inst_mem_op = 1'b0;
    logic [31:0] wave_id = '0;
    logic [31:0] block_dim = '0;
    logic        mem_req;
    logic        mem_resp_valid = 1'b0;
    logic [2:0]  simd_state;
    logic [0:0]  curr_wave_cycle;
    logic        rf_enable;
    logic        reg_write;
    logic [15:0] lane_active;
    logic        done;

    int checks = 0;
    int errors = 0;

    localparam logic [24:0] IDLE_VEC = {1'b1, 24'd0};

    simd_wave_sequencer dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_ready     (issue_ready),
        .inst_reg_write  (inst_reg_write),
        .inst_mem_op     (inst_mem_op),
        .wave_id         (wave_id),
        .block_dim       (block_dim),
        .mem_req         (mem_req),
        .mem_resp_valid  (mem_resp_valid),
        .simd_state      (simd_state),
        .curr_wave_cycle (curr_wave_cycle),
        .rf_enable       (rf_enable),
        .reg_write       (reg_write),
        .lane_active     (lane_active),
        .done            (done)
    );

    always #5 clk = ~clk;

    // {issue_ready, state, pass, rf_enable, reg_write, mem_req, done, lane_active}
    function automatic logic [24:0] obs();
        return {issue_ready, simd_state, curr_wave_cycle, rf_enable, reg_write,
                mem_req, done, lane_active};
    endfunction

    function automatic logic [15:0] lanes(input logic [31:0] w, input logic [31:0] d, input int p);
        logic [15:0] m;
        logic [31:0] t;
        for (int i = 0; i < 16; i++) begin
            t = w * 32 + p * 16 + i;
            m[i] = (t < d);
        end
        return m;
    endfunction

    // Runs one instruction from the IDLE cycle through DONE, checking every cycle.
    task automatic run_inst(input string name, input logic [31:0] w, input logic [31:0] d,
                            input bit mem, input bit rw, input int w0, input int w1,
                            input bit hold_valid);
        logic [24:0] exp_q[$];
        bit          resp_q[$];
        bit          noise_q[$];
        logic [31:0] base;
        logic [15:0] m;
        int          wl;
        for (int p = 0; p < 2; p++) begin
            base = w * 32 + p * 16;
            if (!(base < d)) break;
            m  = lanes(w, d, p);
            wl = (p == 0) ? w0 : w1;
            exp_q.push_back({1'b0, 3'd1, p[0], 1'b1, 1'b0, 1'b0, 1'b0, m});
            resp_q.push_back(0); noise_q.push_back(1);
            exp_q.push_back({1'b0, 3'd2, p[0], 1'b0, 1'b0, 1'b0, 1'b0, m});
            resp_q.push_back(0); noise_q.push_back(1);
            if (mem) begin
                for (int k = 0; k < wl; k++) begin
                    exp_q.push_back({1'b0, 3'd3, p[0], 1'b0, 1'b0, k == 0, 1'b0, m});
                    resp_q.push_back(k == wl - 1); noise_q.push_back(0);
                end
            end
            exp_q.push_back({1'b0, 3'd4, p[0], 1'b1, rw, 1'b0, 1'b0, m});
            resp_q.push_back(0); noise_q.push_back(1);
        end
        exp_q.push_back({1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0});
        resp_q.push_back(0); noise_q.push_back(1);

        @(negedge clk);
        checks++;
        if (obs() !== IDLE_VEC) begin
            errors++;
            $display("FAIL %s idle-before got %h exp %h", name, obs(), IDLE_VEC);
        end
        issue_valid = 1'b1; wave_id = w; block_dim = d;
        inst_mem_op = mem; inst_reg_write = rw; mem_resp_valid = 1'b0;
        for (int c = 0; c < exp_q.size(); c++) begin
            @(negedge clk);
            issue_valid    = hold_valid;
            wave_id        = $urandom_range(0, 3);
            block_dim      = $urandom_range(0, 200);
            inst_mem_op    = $urandom_range(0, 1);
            inst_reg_write = $urandom_range(0, 1);
            checks++;
            if (obs() !== exp_q[c]) begin
                errors++;
                $display("FAIL %s cycle %0d got %h exp %h", name, c + 1, obs(), exp_q[c]);
            end
            mem_resp_valid = resp_q[c] ? 1'b1 : (noise_q[c] ? 1'($urandom_range(0, 1)) : 1'b0);
        end
        issue_valid = 1'b0;
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        checks++;
        if (obs() !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset got %h exp %h", obs(), IDLE_VEC);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nonmem();
        run_inst("full_two_pass", 32'd0, 32'd64, 1'b0, 1'b1, 1, 1, 1'b0);
        run_inst("skip_pass1", 32'd1, 32'd40, 1'b0, 1'b1, 1, 1, 1'b0);
        run_inst("skip_all", 32'd1, 32'd32, 1'b0, 1'b1, 1, 1, 1'b0);
        run_inst("partial_pass1", 32'd2, 32'd85, 1'b0, 1'b0, 1, 1, 1'b0);
        run_inst("dim_zero", 32'd0, 32'd0, 1'b1, 1'b1, 1, 1, 1'b0);
    endtask

    task automatic test_mem_wait();
        run_inst("mem_wait4", 32'd0, 32'd64, 1'b1, 1'b1, 4, 4, 1'b0);
        run_inst("mem_wait1", 32'd0, 32'd64, 1'b1, 1'b0, 1, 1, 1'b0);
        run_inst("mem_mixed", 32'd3, 32'd113, 1'b1, 1'b1, 2, 3, 1'b0);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        issue_valid = 1'b1; wave_id = 32'd0; block_dim = 32'd64;
        inst_mem_op = 1'b1; inst_reg_write = 1'b1; mem_resp_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            issue_valid = 1'b0;
        end
        checks++;
        if (simd_state !== 3'd3 || mem_req !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup got state %0d mem_req %b exp 3 1", simd_state, mem_req);
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs() !== IDLE_VEC) begin
            errors++;
            $display("FAIL areset_immediate got %h exp %h", obs(), IDLE_VEC);
        end
        #1 rst = 1'b0;
        mem_resp_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (obs() !== IDLE_VEC) begin
                errors++;
                $display("FAIL areset_after cycle %0d got %h exp %h", c, obs(), IDLE_VEC);
            end
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        run_inst("b2b_first", 32'd0, 32'd64, 1'b0, 1'b1, 1, 1, 1'b1);
        run_inst("b2b_second", 32'd0, 32'd20, 1'b1, 1'b0, 2, 1, 1'b1);
        run_inst("b2b_third", 32'd1, 32'd50, 1'b0, 1'b1, 1, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] w, d;
        for (int n = 0; n < 30; n++) begin
            w = $urandom_range(0, 4);
            d = $urandom_range(0, 160);
            run_inst("random", w, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 5), $urandom_range(1, 5), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_mem_wait();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
